// File: rtl/cec_hub.sv
// cec_hub: joins NPORTS open-drain CEC segments into one logical bus.
// The first port seen low becomes owner; the hub pulls every other port low
// until the owner lets go. A settle window after each release stops the hub
// from latching onto its own falling echo. A watchdog frees every line if
// the bus stays low abnormally long.
// Optional deglitch filter: define CECHUB_FILTER_EN.
module cec_hub #(
  parameter int NPORTS          = 3,
  parameter int SETTLE_CYCLES   = 8191,
  parameter int WATCHDOG_CYCLES = 1048575,
  parameter int FILTER_CYCLES   = 15,
  localparam int IW = (NPORTS > 2) ? $clog2(NPORTS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NPORTS-1:0] i_cec,
  output logic [NPORTS-1:0] o_cec,
  output logic              o_busy,
  output logic [IW-1:0]     o_owner,
  output logic              o_wderr
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WW = ($clog2(WATCHDOG_CYCLES) > 20) ? $clog2(WATCHDOG_CYCLES) : 20;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WD_LIMIT    = WW'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    SETTLE = 2'd2,
    WDERR  = 2'd3
  } state_t;

  logic [NPORTS-1:0] sync1_q, sync2_q, ck_q;
  logic [NPORTS-1:0] lvl;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [NPORTS-1:0] cec_q, cec_d;
  logic              busy_q, busy_d;
  logic              wderr_q, wderr_d;

  logic              all_high;
  logic [IW-1:0]     low_idx;

  // Three-stage synchroniser per pad; idles released (1) out of reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      ck_q    <= '1;
    end else begin
      sync1_q <= i_cec;
      sync2_q <= sync1_q;
      ck_q    <= sync2_q;
    end
  end

`ifdef CECHUB_FILTER_EN
  localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

  logic [NPORTS-1:0] filt_q, filt_d;
  logic [FCW-1:0]    fcnt_q [NPORTS];
  logic [FCW-1:0]    fcnt_d [NPORTS];

  // Filtered level follows ck only after the new value has persisted FILTER_CYCLES clocks
  always_comb begin
    filt_d = filt_q;
    for (int k = 0; k < NPORTS; k++) begin
      fcnt_d[k] = '0;
      if (ck_q[k] != filt_q[k]) begin
        if (fcnt_q[k] == FILT_LAST) begin
          filt_d[k] = ck_q[k];
        end else begin
          fcnt_d[k] = fcnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Filter state registers; filtered levels come out of reset released
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      filt_q <= '1;
      for (int k = 0; k < NPORTS; k++) fcnt_q[k] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int k = 0; k < NPORTS; k++) fcnt_q[k] <= fcnt_d[k];
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = ck_q;
`endif

  assign all_high = &lvl;

  // Lowest-index low port wins ties between simultaneous falls
  always_comb begin
    low_idx = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (!lvl[k]) low_idx = IW'(k);
    end
  end

  // Next-state, registered-output and watchdog logic; the watchdog overrides all
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    timer_d = timer_q;
    cec_d   = cec_q;
    busy_d  = busy_q;
    wderr_d = wderr_q;

    if (all_high) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      IDLE: begin
        cec_d   = '1;
        busy_d  = 1'b0;
        wderr_d = 1'b0;
        if (!all_high) begin
          owner_d = low_idx;
          for (int k = 0; k < NPORTS; k++) cec_d[k] = (IW'(k) == low_idx);
          busy_d  = 1'b1;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (lvl[owner_q]) begin
          cec_d   = '1;
          busy_d  = 1'b0;
          timer_d = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cec_d  = '1;
        busy_d = 1'b0;
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WDERR: begin
        cec_d   = '1;
        busy_d  = 1'b0;
        wderr_d = 1'b1;
        if (all_high) begin
          wderr_d = 1'b0;
          timer_d = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      default: begin
        cec_d   = '1;
        busy_d  = 1'b0;
        wderr_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if ((state_q != WDERR) && (wd_q == WD_LIMIT)) begin
      cec_d   = '1;
      busy_d  = 1'b0;
      wderr_d = 1'b1;
      state_d = WDERR;
    end
  end

  // State and output registers; reset releases every line at once
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      timer_q <= '0;
      wd_q    <= '0;
      cec_q   <= '1;
      busy_q  <= 1'b0;
      wderr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      wd_q    <= wd_d;
      cec_q   <= cec_d;
      busy_q  <= busy_d;
      wderr_q <= wderr_d;
    end
  end

  assign o_cec   = cec_q;
  assign o_busy  = busy_q;
  assign o_owner = owner_q;
  assign o_wderr = wderr_q;

endmodule

// File: tb/tb_cec_hub.sv
// Directed bench for cec_hub: acquire/release latency, ties, settle rearm,
// loop-back echo rejection, watchdog, async reset and (when built with
// CECHUB_FILTER_EN) glitch rejection.
module tb_cec_hub;

  localparam int NP = 3;
`ifdef CECHUB_FILTER_EN
  localparam int LAT    = 19;
  localparam int SETTLE = 32;
`else
  localparam int LAT    = 4;
  localparam int SETTLE = 16;
`endif
  localparam int WD_MAIN   = 1000;
  localparam int WD_SHORT  = 100;
  localparam int WD_SETTLE = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NP-1:0] ext_main = '1;
  logic [NP-1:0] ext_wd = '1;
  logic          loop_en = 1'b0;
  logic [NP-1:0] main_pad;

  logic [NP-1:0] main_cec, wd_cec;
  logic          main_busy, wd_busy;
  logic [1:0]    main_owner, wd_owner;
  logic          main_wderr, wd_wderr;

  int checks = 0;
  int errors = 0;
  int episode_cnt = 0;
  int ep_start;
  logic busy_prev = 1'b0;

  // Pad model: the wire is low if either the external device or the hub pulls it
  assign main_pad = ext_main & (loop_en ? main_cec : {NP{1'b1}});

  cec_hub #(
    .NPORTS(NP), .SETTLE_CYCLES(SETTLE), .WATCHDOG_CYCLES(WD_MAIN), .FILTER_CYCLES(15)
  ) u_main (
    .i_clk(clk), .i_reset_n(rst_n), .i_cec(main_pad), .o_cec(main_cec),
    .o_busy(main_busy), .o_owner(main_owner), .o_wderr(main_wderr)
  );

  cec_hub #(
    .NPORTS(NP), .SETTLE_CYCLES(WD_SETTLE), .WATCHDOG_CYCLES(WD_SHORT), .FILTER_CYCLES(15)
  ) u_wd (
    .i_clk(clk), .i_reset_n(rst_n), .i_cec(ext_wd), .o_cec(wd_cec),
    .o_busy(wd_busy), .o_owner(wd_owner), .o_wderr(wd_wderr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Counts ownership episodes on the main hub by watching o_busy rise
  always @(negedge clk) begin
    if (main_busy && !busy_prev) episode_cnt = episode_cnt + 1;
    busy_prev = main_busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NP-1:0] main_v, input logic [NP-1:0] wd_v);
    ext_main = main_v;
    ext_wd   = wd_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence
  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    checkOutput("rst_cec", 32'(main_cec), 32'h7);
    checkOutput("rst_busy", 32'(main_busy), 32'h0);
    checkOutput("rst_owner", 32'(main_owner), 32'h0);
    checkOutput("rst_wderr", 32'(main_wderr), 32'h0);
    rst_n = 1'b1;
    tick(5);

    $display("[TB] single owner on port 1");
    applyStimulus(3'b101, 3'b111);
    tick(LAT - 1);
    checkOutput("acq_early", 32'(main_cec), 32'h7);
    tick(1);
    checkOutput("acq_cec", 32'(main_cec), 32'h2);
    checkOutput("acq_busy", 32'(main_busy), 32'h1);
    checkOutput("acq_owner", 32'(main_owner), 32'h1);
    tick(200 - LAT);
    checkOutput("hold_cec", 32'(main_cec), 32'h2);
    applyStimulus(3'b111, 3'b111);
    tick(LAT - 1);
    checkOutput("rel_early", 32'(main_cec), 32'h2);
    tick(1);
    checkOutput("rel_cec", 32'(main_cec), 32'h7);
    checkOutput("rel_busy", 32'(main_busy), 32'h0);
    tick(SETTLE + 10);

    $display("[TB] tie between ports 0 and 2, then handover");
    applyStimulus(3'b010, 3'b111);
    tick(LAT);
    checkOutput("tie_owner", 32'(main_owner), 32'h0);
    checkOutput("tie_cec", 32'(main_cec), 32'h1);
    tick(10);
    applyStimulus(3'b011, 3'b111);
    tick(LAT);
    checkOutput("hand_rel", 32'(main_cec), 32'h7);
    tick(SETTLE);
    checkOutput("hand_settle", 32'(main_cec), 32'h7);
    tick(1);
    checkOutput("hand_cec", 32'(main_cec), 32'h4);
    checkOutput("hand_owner", 32'(main_owner), 32'h2);
    checkOutput("hand_busy", 32'(main_busy), 32'h1);
    applyStimulus(3'b111, 3'b111);
    tick(LAT);
    checkOutput("hand_end", 32'(main_cec), 32'h7);
    tick(SETTLE + 10);

    $display("[TB] loop-back echo rejection");
    loop_en  = 1'b1;
    ep_start = episode_cnt;
    applyStimulus(3'b110, 3'b111);
    tick(LAT);
    checkOutput("loop_cec", 32'(main_cec), 32'h1);
    tick(50 - LAT);
    applyStimulus(3'b111, 3'b111);
    tick(LAT);
    checkOutput("loop_rel", 32'(main_cec), 32'h7);
    tick(SETTLE + 20);
    checkOutput("loop_idle", 32'(main_cec), 32'h7);
    checkOutput("loop_busy", 32'(main_busy), 32'h0);
    checkOutput("loop_episodes", 32'(episode_cnt - ep_start), 32'h1);
    loop_en = 1'b0;

    $display("[TB] reset while owned");
    applyStimulus(3'b101, 3'b111);
    tick(LAT);
    checkOutput("prerst_cec", 32'(main_cec), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_cec", 32'(main_cec), 32'h7);
    checkOutput("async_busy", 32'(main_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(LAT - 1);
    checkOutput("reacq_early", 32'(main_cec), 32'h7);
    tick(1);
    checkOutput("reacq_cec", 32'(main_cec), 32'h2);
    checkOutput("reacq_owner", 32'(main_owner), 32'h1);
    applyStimulus(3'b111, 3'b111);
    tick(LAT);
    checkOutput("reacq_rel", 32'(main_cec), 32'h7);
    tick(SETTLE + 10);

    $display("[TB] watchdog on port 2");
    applyStimulus(3'b111, 3'b011);
    tick(LAT);
    checkOutput("wd_acq", 32'(wd_cec), 32'h4);
    tick(WD_SHORT - 2);
    checkOutput("wd_pre_err", 32'(wd_wderr), 32'h0);
    checkOutput("wd_pre_cec", 32'(wd_cec), 32'h4);
    tick(1);
    checkOutput("wd_err", 32'(wd_wderr), 32'h1);
    checkOutput("wd_cec", 32'(wd_cec), 32'h7);
    checkOutput("wd_busy", 32'(wd_busy), 32'h0);
    applyStimulus(3'b111, 3'b111);
    tick(LAT - 1);
    checkOutput("wd_hold", 32'(wd_wderr), 32'h1);
    tick(1);
    checkOutput("wd_clear", 32'(wd_wderr), 32'h0);
    checkOutput("wd_clear_cec", 32'(wd_cec), 32'h7);
    tick(WD_SETTLE + 5);
    applyStimulus(3'b111, 3'b110);
    tick(LAT);
    checkOutput("wd_rearm_cec", 32'(wd_cec), 32'h1);
    checkOutput("wd_rearm_owner", 32'(wd_owner), 32'h0);
    applyStimulus(3'b111, 3'b111);
    tick(LAT);
    checkOutput("wd_rearm_rel", 32'(wd_cec), 32'h7);
    tick(WD_SETTLE + 5);

`ifdef CECHUB_FILTER_EN
    $display("[TB] deglitch filter");
    ep_start = episode_cnt;
    applyStimulus(3'b110, 3'b111);
    tick(10);
    applyStimulus(3'b111, 3'b111);
    tick(40);
    checkOutput("glitch_cec", 32'(main_cec), 32'h7);
    checkOutput("glitch_episodes", 32'(episode_cnt - ep_start), 32'h0);
    applyStimulus(3'b110, 3'b111);
    tick(18);
    checkOutput("filt_early", 32'(main_cec), 32'h7);
    tick(1);
    checkOutput("filt_acq", 32'(main_cec), 32'h1);
    tick(21);
    applyStimulus(3'b111, 3'b111);
    tick(19);
    checkOutput("filt_rel", 32'(main_cec), 32'h7);
    tick(SETTLE + 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
